shrimp_wb_arbiter: RTL and testbench
====================================

SHRIMP_WB_ARBITER -- requirements
Module: shrimp_wb_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports named clock and reset.
REQ-002 SHALL have ports: clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have ports: reset  input  1  synchronous active-high reset.
REQ-004 SHALL have ports: a_valid  input  1 / a_addr  input  4 / a_val  input  16  (source A write request: ALU writeback).
REQ-005 SHALL have ports: a_ready  output  1  source A request accepted at this edge when high with a_valid.
REQ-006 SHALL have ports: b_valid  input  1 / b_addr  input  4 / b_val  input  16 / b_ready  output  1  (source B: load writeback, same meaning).
REQ-007 SHALL have ports: reg_w_enable  output  1 / reg_w_addr  output  4 / reg_w_val  output  16  (registered regfile write port).
REQ-008 SHALL have ports: rsv_valid  input  1 / rsv_addr  input  4  (issue stage reserves a destination register).
REQ-009 SHALL have ports: busy  output  16  (one pending-write bit per register; bit 15 constant 0).

Function
REQ-010 SHALL hold one single-entry buffer (full flag, addr, val) per source.
REQ-011 SHALL drive x_ready = NOT x_full AND NOT reset.
REQ-012 SHALL capture x_addr/x_val into x's buffer at an edge where x_valid AND x_ready AND x_addr != 0xF.
REQ-013 SHALL discard a handshake with x_addr == 0xF: buffer stays empty, no write, busy unchanged.
REQ-014 SHALL each cycle grant at most one full buffer: only A full -> A; only B full -> B; both full -> source selected by round-robin pointer.
REQ-015 SHALL set the round-robin pointer, at the edge after every grant, to the non-granted source; pointer unchanged when no grant.
REQ-016 SHALL, at the edge ending a grant cycle, clear the granted buffer and register reg_w_enable=1, reg_w_addr/reg_w_val = granted entry.
REQ-017 SHALL register reg_w_enable=0 in any cycle with no grant; reg_w_addr/reg_w_val then hold previous values.
REQ-018 SHALL give latency of exactly one cycle from capture edge to reg_w_enable high when uncontended (capture at edge E0, write visible after E1).
REQ-019 SHALL not let a buffer accept a new entry in the cycle it is granted (ready is derived from registered full only); per-source throughput one write per two cycles.
REQ-020 SHALL write both entries in grant order when A and B target the same address; the later write wins in the regfile.
REQ-021 SHALL never drive reg_w_enable=1 with reg_w_addr == 0xF.

Reset
REQ-022 SHALL, on reset, clear both full flags, set pointer to A, clear busy, drive reg_w_enable=0, reg_w_addr=0, reg_w_val=0.
REQ-023 SHALL discard buffered, uncommitted writes when reset asserts mid-operation; no write issues in the cycle after reset.
REQ-024 SHALL hold a_ready=b_ready=0 while reset is high; both become 1 in the first cycle after reset deasserts.

Configuration
REQ-025 SHALL compile the scoreboard only when macro SHRIMP_WB_SCOREBOARD_EN is defined.
REQ-026 SHALL, with SHRIMP_WB_SCOREBOARD_EN: set busy[rsv_addr] at the edge where rsv_valid=1 and rsv_addr != 0xF; clear busy[reg_w_addr] at the edge a grant is registered; simultaneous set and clear of the same bit -> set wins.
REQ-027 SHALL, without SHRIMP_WB_SCOREBOARD_EN: tie busy to 0, ignore rsv_valid/rsv_addr, no scoreboard flops.

Verification
REQ-028 SHALL cover: A only, a_addr=3, a_val=0x1234 -> reg_w_enable=1, addr 3, val 0x1234 one cycle after capture; a_ready=0 for one cycle.
REQ-029 SHALL cover: A and B captured same edge (addr 1/0xAAAA, addr 2/0xBBBB) after reset -> A written first cycle, B next cycle.
REQ-030 SHALL cover: both sources continuously valid for 8 writes -> grants strictly alternate A,B,A,B; no cycle with two writes or lost entries.
REQ-031 SHALL cover: a_addr=0xF, a_val=0xFFFF -> handshake completes, reg_w_enable stays 0, a_ready stays 1.
REQ-032 SHALL cover (scoreboard on): rsv 5 -> busy=0x0020; A write addr 5 -> busy=0x0000 at same edge reg_w_enable rises; rsv 5 in that same cycle -> busy stays 0x0020.
REQ-033 SHALL cover: reset asserted with both buffers full -> no write follows, busy=0, ready=0 during reset and 1 after.

Source files
------------

// File: rtl/shrimp_wb_arbiter.sv
// Two-source register-file writeback arbiter: single-entry buffer per source, round-robin grant.
// Optional pending-write scoreboard on busy[] is built only when SHRIMP_WB_SCOREBOARD_EN is defined.
module shrimp_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_val,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_val,
    output logic              b_ready,
    output logic              reg_w_enable,
    output logic [ADDR_W-1:0] reg_w_addr,
    output logic [DATA_W-1:0] reg_w_val,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [15:0]       busy
);

    localparam logic [ADDR_W-1:0] NULL_REG = '1;

    logic              a_full;
    logic [ADDR_W-1:0] a_buf_addr;
    logic [DATA_W-1:0] a_buf_val;
    logic              b_full;
    logic [ADDR_W-1:0] b_buf_addr;
    logic [DATA_W-1:0] b_buf_val;
    logic              rr_ptr;      // 0: A preferred on contention, 1: B preferred

    logic              grant_a;
    logic              grant_b;
    logic              a_take;
    logic              b_take;

    // Ready depends on registered full only, so a buffer never refills in its grant cycle.
    assign a_ready = !a_full && !reset;
    assign b_ready = !b_full && !reset;

    assign a_take = a_valid && a_ready && (a_addr != NULL_REG);
    assign b_take = b_valid && b_ready && (b_addr != NULL_REG);

    always_comb begin
        grant_a = a_full && (!b_full || !rr_ptr);
        grant_b = b_full && (!a_full || rr_ptr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_full       <= 1'b0;
            b_full       <= 1'b0;
            rr_ptr       <= 1'b0;
            reg_w_enable <= 1'b0;
            reg_w_addr   <= '0;
            reg_w_val    <= '0;
        end else begin
            if (a_take) begin
                a_full     <= 1'b1;
                a_buf_addr <= a_addr;
                a_buf_val  <= a_val;
            end else if (grant_a) begin
                a_full <= 1'b0;
            end

            if (b_take) begin
                b_full     <= 1'b1;
                b_buf_addr <= b_addr;
                b_buf_val  <= b_val;
            end else if (grant_b) begin
                b_full <= 1'b0;
            end

            if (grant_a) begin
                reg_w_enable <= 1'b1;
                reg_w_addr   <= a_buf_addr;
                reg_w_val    <= a_buf_val;
                rr_ptr       <= 1'b1;
            end else if (grant_b) begin
                reg_w_enable <= 1'b1;
                reg_w_addr   <= b_buf_addr;
                reg_w_val    <= b_buf_val;
                rr_ptr       <= 1'b0;
            end else begin
                reg_w_enable <= 1'b0;
            end
        end
    end

`ifdef SHRIMP_WB_SCOREBOARD_EN
    logic [15:0]       busy_q;
    logic [15:0]       busy_next;
    logic [ADDR_W-1:0] grant_addr;

    assign grant_addr = grant_a ? a_buf_addr : b_buf_addr;

    // Clear is applied first so a same-cycle reservation of the same register wins.
    always_comb begin
        busy_next = busy_q;
        if ((grant_a || grant_b) && (grant_addr != NULL_REG)) begin
            busy_next[grant_addr] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != NULL_REG)) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[15] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy = busy_q;
`else
    logic unused_rsv;
    assign unused_rsv = ^{rsv_valid, rsv_addr};
    assign busy       = '0;
`endif

endmodule

// File: tb/tb_shrimp_wb_arbiter.sv
// Directed self-checking bench for shrimp_wb_arbiter; busy expectations follow SHRIMP_WB_SCOREBOARD_EN.
module tb_shrimp_wb_arbiter;

`ifdef SHRIMP_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        a_valid;
    logic [3:0]  a_addr;
    logic [15:0] a_val;
    logic        a_ready;
    logic        b_valid;
    logic [3:0]  b_addr;
    logic [15:0] b_val;
    logic        b_ready;
    logic        reg_w_enable;
    logic [3:0]  reg_w_addr;
    logic [15:0] reg_w_val;
    logic        rsv_valid;
    logic [3:0]  rsv_addr;
    logic [15:0] busy;

    int tests_run = 0;
    int tests_failed = 0;

    shrimp_wb_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_addr       (a_addr),
        .a_val        (a_val),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_addr       (b_addr),
        .b_val        (b_val),
        .b_ready      (b_ready),
        .reg_w_enable (reg_w_enable),
        .reg_w_addr   (reg_w_addr),
        .reg_w_val    (reg_w_val),
        .rsv_valid    (rsv_valid),
        .rsv_addr     (rsv_addr),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_addr = 0; a_val = 0;
        b_valid = 0; b_addr = 0; b_val = 0;
        rsv_valid = 0; rsv_addr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        chk("rst_a_ready", {15'd0, a_ready}, 16'd0);
        chk("rst_b_ready", {15'd0, b_ready}, 16'd0);
        chk("rst_wen", {15'd0, reg_w_enable}, 16'd0);
        chk("rst_waddr", {12'd0, reg_w_addr}, 16'd0);
        chk("rst_wval", reg_w_val, 16'd0);
        chk("rst_busy", busy, 16'd0);
        reset = 0;
        #1;
        chk("post_rst_a_ready", {15'd0, a_ready}, 16'd1);
        chk("post_rst_b_ready", {15'd0, b_ready}, 16'd1);
    endtask

    task automatic test_a_only();
        do_reset();
        a_valid = 1; a_addr = 4'd3; a_val = 16'h1234;
        step();
        a_valid = 0; #1;
        chk("a_only_ready_low", {15'd0, a_ready}, 16'd0);
        chk("a_only_wen_e0", {15'd0, reg_w_enable}, 16'd0);
        step();
        chk("a_only_wen_e1", {15'd0, reg_w_enable}, 16'd1);
        chk("a_only_addr", {12'd0, reg_w_addr}, 16'd3);
        chk("a_only_val", reg_w_val, 16'h1234);
        chk("a_only_ready_back", {15'd0, a_ready}, 16'd1);
        step();
        chk("a_only_wen_drop", {15'd0, reg_w_enable}, 16'd0);
        chk("a_only_addr_hold", {12'd0, reg_w_addr}, 16'd3);
        chk("a_only_val_hold", reg_w_val, 16'h1234);
    endtask

    task automatic test_same_edge();
        do_reset();
        a_valid = 1; a_addr = 4'd1; a_val = 16'hAAAA;
        b_valid = 1; b_addr = 4'd2; b_val = 16'hBBBB;
        step();
        a_valid = 0; b_valid = 0; #1;
        chk("same_a_ready", {15'd0, a_ready}, 16'd0);
        chk("same_b_ready", {15'd0, b_ready}, 16'd0);
        step();
        chk("same_first_wen", {15'd0, reg_w_enable}, 16'd1);
        chk("same_first_addr", {12'd0, reg_w_addr}, 16'd1);
        chk("same_first_val", reg_w_val, 16'hAAAA);
        chk("same_b_still_full", {15'd0, b_ready}, 16'd0);
        step();
        chk("same_second_wen", {15'd0, reg_w_enable}, 16'd1);
        chk("same_second_addr", {12'd0, reg_w_addr}, 16'd2);
        chk("same_second_val", reg_w_val, 16'hBBBB);
        step();
        chk("same_done_wen", {15'd0, reg_w_enable}, 16'd0);
    endtask

    task automatic test_back_to_back();
        int a_idx = 0;
        int b_idx = 0;
        bit a_acc;
        bit b_acc;
        logic [15:0] exp_val;
        logic [15:0] exp_addr;
        do_reset();
        a_valid = 1; a_addr = 4'd4;
        b_valid = 1; b_addr = 4'd6;
        for (int k = 0; k <= 8; k++) begin
            a_val = 16'hA000 | 16'(a_idx);
            b_val = 16'hB000 | 16'(b_idx);
            a_acc = a_ready;
            b_acc = b_ready;
            step();
            if (a_acc) a_idx++;
            if (b_acc) b_idx++;
            if (k > 0) begin
                exp_val  = ((k - 1) % 2 == 0) ? (16'hA000 | 16'((k - 1) / 2))
                                              : (16'hB000 | 16'((k - 1) / 2));
                exp_addr = ((k - 1) % 2 == 0) ? 16'd4 : 16'd6;
                chk($sformatf("rr_wen_%0d", k - 1), {15'd0, reg_w_enable}, 16'd1);
                chk($sformatf("rr_addr_%0d", k - 1), {12'd0, reg_w_addr}, exp_addr);
                chk($sformatf("rr_val_%0d", k - 1), reg_w_val, exp_val);
            end
        end
        idle_inputs();
        do_reset();
    endtask

    task automatic test_null_addr();
        do_reset();
        a_valid = 1; a_addr = 4'hF; a_val = 16'hFFFF;
        #1;
        chk("null_ready_pre", {15'd0, a_ready}, 16'd1);
        step();
        a_valid = 0; #1;
        chk("null_ready_post", {15'd0, a_ready}, 16'd1);
        chk("null_wen_e0", {15'd0, reg_w_enable}, 16'd0);
        step();
        chk("null_wen_e1", {15'd0, reg_w_enable}, 16'd0);
        chk("null_busy", busy, 16'd0);
    endtask

    task automatic test_scoreboard();
        do_reset();
        rsv_valid = 1; rsv_addr = 4'd5;
        step();
        rsv_valid = 0;
        chk("sb_rsv5", busy, SB ? 16'h0020 : 16'h0000);
        rsv_valid = 1; rsv_addr = 4'hF;
        step();
        rsv_valid = 0;
        chk("sb_rsv_null", busy, SB ? 16'h0020 : 16'h0000);
        a_valid = 1; a_addr = 4'd5; a_val = 16'h5555;
        step();
        a_valid = 0;
        chk("sb_captured", busy, SB ? 16'h0020 : 16'h0000);
        step();
        chk("sb_clear_wen", {15'd0, reg_w_enable}, 16'd1);
        chk("sb_clear", busy, 16'h0000);
        a_valid = 1; a_addr = 4'd5; a_val = 16'h6666;
        step();
        a_valid = 0;
        rsv_valid = 1; rsv_addr = 4'd5;
        step();
        rsv_valid = 0;
        chk("sb_set_wins_wen", {15'd0, reg_w_enable}, 16'd1);
        chk("sb_set_wins", busy, SB ? 16'h0020 : 16'h0000);
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsv_valid = 1; rsv_addr = 4'd9;
        a_valid = 1; a_addr = 4'd7; a_val = 16'h7777;
        b_valid = 1; b_addr = 4'd8; b_val = 16'h8888;
        step();
        idle_inputs();
        chk("mid_busy_pre", busy, SB ? 16'h0200 : 16'h0000);
        reset = 1;
        #1;
        chk("mid_a_ready_rst", {15'd0, a_ready}, 16'd0);
        chk("mid_b_ready_rst", {15'd0, b_ready}, 16'd0);
        step();
        chk("mid_wen_rst", {15'd0, reg_w_enable}, 16'd0);
        chk("mid_busy_rst", busy, 16'd0);
        reset = 0;
        #1;
        chk("mid_a_ready_after", {15'd0, a_ready}, 16'd1);
        chk("mid_b_ready_after", {15'd0, b_ready}, 16'd1);
        step();
        chk("mid_wen_after1", {15'd0, reg_w_enable}, 16'd0);
        step();
        chk("mid_wen_after2", {15'd0, reg_w_enable}, 16'd0);
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_a_only();
        test_same_edge();
        test_back_to_back();
        test_null_addr();
        test_scoreboard();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
